prach_uplane_packer: RTL and testbench
======================================

# prach_uplane_packer

PRACH U-plane packer on the `clk_eth_xran` domain, directly upstream of the O-RAN U-plane source interface (`avst_source_u_*`, `tx_u_*`) of `prach_top`. It takes one section header per packet, plus a serial stream of 32-bit IQ samples from the PRACH filter chain. It packs four samples per 128-bit Avalon-ST beat and drives packet framing and eCPRI/O-RAN header fields, honouring `avst_source_u_ready` backpressure.

## Interface
- No parameters; all widths fixed.
- `clk_eth_xran` in 1: single clock, 402.83203125 MHz.
- `rst_eth_xran` in 1: synchronous, active-high reset.
- `hdr_valid` in 1, `hdr_ready` out 1: section header handshake.
- `hdr_pc_id` in 16, `hdr_filterIndex` in 4, `hdr_frameId` in 8, `hdr_subframeId` in 4, `hdr_slotId` in 6, `hdr_symbolId` in 6, `hdr_sectionId` in 12, `hdr_startPrb` in 10, `hdr_numPrb` in 8, `hdr_udCompHdr` in 8: header fields for the next packet.
- `din_valid` in 1, `din_ready` out 1, `din_data` in 32: IQ sample, I = [31:16], Q = [15:0].
- `avst_source_u_data` out 128, `avst_source_u_valid` out 1, `avst_source_u_startofpacket` out 1, `avst_source_u_endofpacket` out 1, `avst_source_u_ready` in 1: packet stream.
- `tx_u_size` out 16, `tx_u_pc_id` out 16, `tx_u_seq_id` out 16, `tx_u_dataDirection` out 1, `tx_u_payloadVersion` out 3, `tx_u_filterIndex` out 4, `tx_u_frameId` out 8, `tx_u_subframeId` out 4, `tx_u_slotID` out 6, `tx_u_symbolid` out 6, `tx_u_sectionId` out 12, `tx_u_rb` out 1, `tx_u_symInc` out 1, `tx_u_startPrb` out 10, `tx_u_numPrb` out 8, `tx_u_udCompHdr` out 8: per-packet sideband.

## Operation
- **FSM states: IDLE, DATA.**
  - IDLE: `hdr_ready`=1 and `din_ready`=0.
- **Header accept** (`hdr_valid & hdr_ready` in IDLE):
  - `hdr_numPrb`=0: header is consumed, no packet, state stays IDLE, seq counter unchanged.
  - Otherwise: latch all hdr fields into the `tx_u_*` registers and go to DATA.
  - Set the sample counter to `numPrb*12` (12-bit) and `tx_u_size` = `numPrb*48` bytes (16-bit).
- **Constant fields:** `tx_u_dataDirection`=0 (UL), `tx_u_payloadVersion`=3'd1, `tx_u_rb`=0, `tx_u_symInc`=0.
- **`tx_u_seq_id`** = {seq_cnt[7:0], 8'h80}: E-bit set, subsequence 0. seq_cnt increments on each EOP beat accepted and wraps 255→0.
- **Packing:**
  - The pack register collects 4 samples. Sample k of a beat goes to bits [127-32k -: 32], so the first sample occupies the MSBs (network order).
  - `numPrb*12` is always divisible by 4, so every beat is full; there is no partial-beat path.
- **Output register:** when the 4th sample is accepted, the pack register is copied into the output register and `avst_source_u_valid` is set.
  - SOP is set on the first beat of the packet, EOP on beat number `numPrb*3`.
- **`din_ready`** = (state==DATA) & (samples_left>0) & (pack_cnt<3 | ~out_valid | `avst_source_u_ready`).
- **Exit from DATA:** on acceptance of the EOP beat (valid & ready & eop), go to IDLE. `hdr_ready` rises the following cycle.
- **Sideband hold:** `tx_u_*` stay stable from header accept until the next header accept; they are valid throughout the packet.

## Timing
- **Reset values:** all outputs are 0 except the constant fields, which keep the values listed above.
  - seq_cnt=0, so `tx_u_seq_id`=16'h0080.
  - FSM in IDLE, so `hdr_ready`=1 on the first cycle after reset is released.
- **Latency:**
  - Header accept at cycle N → `din_ready` can be 1 at N+1.
  - 4th sample accepted at cycle M → beat valid at M+1.
- **Throughput:** 1 sample/cycle sustained with `avst_source_u_ready`=1, giving 1 beat every 4 cycles.
- **Avalon-ST rules:**
  - data, SOP and EOP stay stable while valid=1 and ready=0.
  - valid never drops without a handshake.
  - ready may toggle freely.
- **Backpressure:** with out_valid=1 and ready=0, samples 1–3 of the next beat are still accepted. The 4th is held off (`din_ready`=0) until the output register frees.
  - A simultaneous output accept and 4th-sample accept in the same cycle reloads the output register with no bubble.
- **Headers during DATA:** not accepted; `hdr_valid` may stay asserted.
- **Reset mid-packet:** the packet is abandoned immediately. No EOP is emitted, `avst_source_u_valid` drops the cycle after reset, and seq_cnt returns to 0.

## Test plan
- **Single packet:** reset, header numPrb=1 (frameId=8'h12, symbolId=6'd3), samples 0x00000001..0x0000000C back-to-back with ready=1.
  - Expect 3 beats.
  - Beat0 = 128'h00000001_00000002_00000003_00000004, SOP on beat0, EOP on beat2.
  - `tx_u_size`=48, `tx_u_seq_id`=16'h0080.
- **Back-to-back packets:** two headers, numPrb=2 then numPrb=255.
  - Expect 6 beats then 765 beats.
  - seq_id 0x0080 then 0x0180.
  - `tx_u_size`=96 then 12240.
- **Backpressure:** ready held 0 for 10 cycles after the first beat becomes valid.
  - beat0 stays stable and `din_ready` drops after 3 more samples.
  - The full payload is delivered in order with no loss or duplication.
- **numPrb=0:** header accepted and no beats emitted; the next header (numPrb=1) gets seq_id 0x0080.
- **Seq wrap:** 257 packets of numPrb=1 → packet 257 has seq_id 0x0080.
- **Reset mid-packet:** assert reset after 5 beats of a numPrb=4 packet.
  - Outputs return to their reset values.
  - A following packet has SOP on its first beat and seq_id 0x0080.

Source files
------------

// File: rtl/prach_uplane_packer.sv
// PRACH U-plane packer: packs four 32-bit IQ samples per 128-bit Avalon-ST beat
// and drives the per-packet O-RAN/eCPRI sideband fields from one section header.
//
// state | meaning
// IDLE  | waiting for a section header; hdr_ready=1, din_ready=0
// DATA  | collecting samples and emitting beats until the EOP beat is accepted
module prach_uplane_packer (
    input  logic         clk_eth_xran,
    input  logic         rst_eth_xran,
    input  logic         hdr_valid,
    output logic         hdr_ready,
    input  logic [15:0]  hdr_pc_id,
    input  logic [3:0]   hdr_filterIndex,
    input  logic [7:0]   hdr_frameId,
    input  logic [3:0]   hdr_subframeId,
    input  logic [5:0]   hdr_slotId,
    input  logic [5:0]   hdr_symbolId,
    input  logic [11:0]  hdr_sectionId,
    input  logic [9:0]   hdr_startPrb,
    input  logic [7:0]   hdr_numPrb,
    input  logic [7:0]   hdr_udCompHdr,
    input  logic         din_valid,
    output logic         din_ready,
    input  logic [31:0]  din_data,
    output logic [127:0] avst_source_u_data,
    output logic         avst_source_u_valid,
    output logic         avst_source_u_startofpacket,
    output logic         avst_source_u_endofpacket,
    input  logic         avst_source_u_ready,
    output logic [15:0]  tx_u_size,
    output logic [15:0]  tx_u_pc_id,
    output logic [15:0]  tx_u_seq_id,
    output logic         tx_u_dataDirection,
    output logic [2:0]   tx_u_payloadVersion,
    output logic [3:0]   tx_u_filterIndex,
    output logic [7:0]   tx_u_frameId,
    output logic [3:0]   tx_u_subframeId,
    output logic [5:0]   tx_u_slotID,
    output logic [5:0]   tx_u_symbolid,
    output logic [11:0]  tx_u_sectionId,
    output logic         tx_u_rb,
    output logic         tx_u_symInc,
    output logic [9:0]   tx_u_startPrb,
    output logic [7:0]   tx_u_numPrb,
    output logic [7:0]   tx_u_udCompHdr
);

    typedef enum logic {IDLE = 1'b0, DATA = 1'b1} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [11:0] samples_left;
    logic [1:0]  pack_cnt;
    logic [95:0] pack_reg;
    logic        first_beat;
    logic [7:0]  seq_cnt;
    logic        hdr_fire;
    logic        din_fire;
    logic        out_fire;
    logic        eop_fire;

    assign hdr_fire = hdr_valid & hdr_ready;
    assign din_fire = din_valid & din_ready;
    assign out_fire = avst_source_u_valid & avst_source_u_ready;
    assign eop_fire = out_fire & avst_source_u_endofpacket;

    assign tx_u_dataDirection  = 1'b0;
    assign tx_u_payloadVersion = 3'd1;
    assign tx_u_rb             = 1'b0;
    assign tx_u_symInc         = 1'b0;
    // E-bit set, subsequence 0
    assign tx_u_seq_id         = {seq_cnt, 8'h80};

    // State register
    always_ff @(posedge clk_eth_xran) begin
        if (rst_eth_xran) state <= IDLE;
        else              state <= state_nxt;
    end

    // Next-state logic; a zero-PRB header is consumed without leaving IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (hdr_valid && hdr_numPrb != 8'd0) state_nxt = DATA;
            DATA: if (eop_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs; the 4th sample waits until the output register can take the beat
    always_comb begin
        hdr_ready = 1'b0;
        din_ready = 1'b0;
        case (state)
            IDLE: hdr_ready = 1'b1;
            DATA: din_ready = (samples_left != 12'd0) &&
                              (pack_cnt != 2'd3 || !avst_source_u_valid || avst_source_u_ready);
            default: ;
        endcase
    end

    // Sideband capture on header accept; fields hold until the next accepted header
    always_ff @(posedge clk_eth_xran) begin
        if (rst_eth_xran) begin
            tx_u_size        <= '0;
            tx_u_pc_id       <= '0;
            tx_u_filterIndex <= '0;
            tx_u_frameId     <= '0;
            tx_u_subframeId  <= '0;
            tx_u_slotID      <= '0;
            tx_u_symbolid    <= '0;
            tx_u_sectionId   <= '0;
            tx_u_startPrb    <= '0;
            tx_u_numPrb      <= '0;
            tx_u_udCompHdr   <= '0;
        end else if (hdr_fire && hdr_numPrb != 8'd0) begin
            tx_u_size        <= 16'(hdr_numPrb) * 16'd48;
            tx_u_pc_id       <= hdr_pc_id;
            tx_u_filterIndex <= hdr_filterIndex;
            tx_u_frameId     <= hdr_frameId;
            tx_u_subframeId  <= hdr_subframeId;
            tx_u_slotID      <= hdr_slotId;
            tx_u_symbolid    <= hdr_symbolId;
            tx_u_sectionId   <= hdr_sectionId;
            tx_u_startPrb    <= hdr_startPrb;
            tx_u_numPrb      <= hdr_numPrb;
            tx_u_udCompHdr   <= hdr_udCompHdr;
        end
    end

    // Sample packing (first sample in the MSBs) and output beat register
    always_ff @(posedge clk_eth_xran) begin
        if (rst_eth_xran) begin
            samples_left                <= '0;
            pack_cnt                    <= '0;
            pack_reg                    <= '0;
            first_beat                  <= 1'b0;
            avst_source_u_data          <= '0;
            avst_source_u_valid         <= 1'b0;
            avst_source_u_startofpacket <= 1'b0;
            avst_source_u_endofpacket   <= 1'b0;
        end else begin
            if (hdr_fire && hdr_numPrb != 8'd0) begin
                samples_left <= 12'(hdr_numPrb) * 12'd12;
                pack_cnt     <= '0;
                first_beat   <= 1'b1;
            end
            if (din_fire) begin
                samples_left <= samples_left - 12'd1;
                pack_cnt     <= pack_cnt + 2'd1;
                case (pack_cnt)
                    2'd0:    pack_reg[95:64] <= din_data;
                    2'd1:    pack_reg[63:32] <= din_data;
                    2'd2:    pack_reg[31:0]  <= din_data;
                    default: ;
                endcase
            end
            // A reload in the same cycle as an output accept takes priority: no bubble
            if (din_fire && pack_cnt == 2'd3) begin
                avst_source_u_data          <= {pack_reg, din_data};
                avst_source_u_valid         <= 1'b1;
                avst_source_u_startofpacket <= first_beat;
                avst_source_u_endofpacket   <= (samples_left == 12'd1);
                first_beat                  <= 1'b0;
            end else if (out_fire) begin
                avst_source_u_valid         <= 1'b0;
                avst_source_u_startofpacket <= 1'b0;
                avst_source_u_endofpacket   <= 1'b0;
            end
        end
    end

    // Packet sequence counter, advanced by each accepted EOP beat
    always_ff @(posedge clk_eth_xran) begin
        if (rst_eth_xran)  seq_cnt <= '0;
        else if (eop_fire) seq_cnt <= seq_cnt + 8'd1;
    end

endmodule

// File: tb/tb_prach_uplane_packer.sv
// Directed bench for prach_uplane_packer: table of packet records plus
// hand-written sequences for sequence wrap and reset in mid-packet.
module tb_prach_uplane_packer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         hdr_valid = 1'b0;
    logic         hdr_ready;
    logic [15:0]  hdr_pc_id = '0;
    logic [3:0]   hdr_filterIndex = '0;
    logic [7:0]   hdr_frameId = '0;
    logic [3:0]   hdr_subframeId = '0;
    logic [5:0]   hdr_slotId = '0;
    logic [5:0]   hdr_symbolId = '0;
    logic [11:0]  hdr_sectionId = '0;
    logic [9:0]   hdr_startPrb = '0;
    logic [7:0]   hdr_numPrb = '0;
    logic [7:0]   hdr_udCompHdr = '0;
    logic         din_valid = 1'b0;
    logic         din_ready;
    logic [31:0]  din_data = '0;
    logic [127:0] src_data;
    logic         src_valid, src_sop, src_eop;
    logic         src_ready = 1'b1;
    logic [15:0]  tx_size, tx_pc_id, tx_seq_id;
    logic         tx_dir, tx_rb, tx_syminc;
    logic [2:0]   tx_pv;
    logic [3:0]   tx_filter, tx_subframe;
    logic [7:0]   tx_frame, tx_numprb, tx_udcomp;
    logic [5:0]   tx_slot, tx_sym;
    logic [11:0]  tx_section;
    logic [9:0]   tx_startprb;

    int errors = 0;
    int checks = 0;

    prach_uplane_packer dut (
        .clk_eth_xran(clk), .rst_eth_xran(rst),
        .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
        .hdr_pc_id(hdr_pc_id), .hdr_filterIndex(hdr_filterIndex),
        .hdr_frameId(hdr_frameId), .hdr_subframeId(hdr_subframeId),
        .hdr_slotId(hdr_slotId), .hdr_symbolId(hdr_symbolId),
        .hdr_sectionId(hdr_sectionId), .hdr_startPrb(hdr_startPrb),
        .hdr_numPrb(hdr_numPrb), .hdr_udCompHdr(hdr_udCompHdr),
        .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
        .avst_source_u_data(src_data), .avst_source_u_valid(src_valid),
        .avst_source_u_startofpacket(src_sop), .avst_source_u_endofpacket(src_eop),
        .avst_source_u_ready(src_ready),
        .tx_u_size(tx_size), .tx_u_pc_id(tx_pc_id), .tx_u_seq_id(tx_seq_id),
        .tx_u_dataDirection(tx_dir), .tx_u_payloadVersion(tx_pv),
        .tx_u_filterIndex(tx_filter), .tx_u_frameId(tx_frame),
        .tx_u_subframeId(tx_subframe), .tx_u_slotID(tx_slot),
        .tx_u_symbolid(tx_sym), .tx_u_sectionId(tx_section),
        .tx_u_rb(tx_rb), .tx_u_symInc(tx_syminc),
        .tx_u_startPrb(tx_startprb), .tx_u_numPrb(tx_numprb),
        .tx_u_udCompHdr(tx_udcomp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_before;
        logic [7:0]  nprb;
        logic [7:0]  frame;
        logic [5:0]  sym;
        logic        bp;
        logic [15:0] exp_seq;
        logic [15:0] exp_size;
        logic [31:0] base;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; hdr_valid = 1'b0; din_valid = 1'b0; src_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        #1;
        chk({tag, "_stream"}, {src_valid, src_sop, src_eop, src_data}, '0);
        chk({tag, "_side"}, {tx_size, tx_pc_id, tx_numprb, tx_frame, tx_sym, tx_section}, '0);
        chk({tag, "_seq"}, tx_seq_id, 16'h0080);
        chk({tag, "_const"}, {tx_dir, tx_pv, tx_rb, tx_syminc}, {1'b0, 3'd1, 1'b0, 1'b0});
        chk({tag, "_ready"}, {hdr_ready, din_ready}, 2'b10);
    endtask

    // Sends one header and streams samples base, base+1, ...; checks every accepted
    // beat against the expected sample packing. abort>0 returns after that many beats.
    task automatic run_packet(input logic [7:0] nprb, input logic [7:0] frame,
                              input logic [5:0] sym, input logic bp,
                              input logic [15:0] exp_seq, input logic [15:0] exp_size,
                              input logic [31:0] base, input int abort);
        int total, exp_beats, sent, beats, stall_left, stall_acc, ncyc;
        logic stalled_once, done, prev_hold, dfire;
        logic [130:0] prev_beat;
        logic [127:0] exp_data;
        total = 12 * int'(nprb);
        exp_beats = 3 * int'(nprb);
        sent = 0; beats = 0; stall_left = 0; stall_acc = 0; ncyc = 0;
        stalled_once = 1'b0; done = 1'b0; prev_hold = 1'b0; prev_beat = '0;

        @(negedge clk);
        hdr_valid = 1'b1; hdr_numPrb = nprb; hdr_frameId = frame; hdr_symbolId = sym;
        hdr_pc_id = 16'hBEEF; hdr_filterIndex = 4'h3; hdr_subframeId = 4'h7;
        hdr_slotId = 6'd21; hdr_sectionId = 12'hABC; hdr_startPrb = 10'd5;
        hdr_udCompHdr = 8'h91; din_valid = 1'b0; src_ready = 1'b1;
        #1 chk("hdr_ready_idle", hdr_ready, 1'b1);
        @(posedge clk);

        for (int cyc = 0; cyc < 40 * total + 100; cyc++) begin
            @(negedge clk);
            hdr_valid = 1'b0;
            if (bp && !stalled_once && src_valid) begin
                stalled_once = 1'b1;
                stall_left = 10;
            end
            src_ready = (stall_left > 0) ? 1'b0 : 1'b1;
            din_valid = (sent < total);
            din_data = base + 32'(sent);
            #1;
            if (cyc == 0) begin
                chk("first_cycle_ready", {hdr_ready, din_ready}, 2'b01);
                chk("sideband", {tx_pc_id, tx_filter, tx_frame, tx_subframe, tx_slot, tx_sym,
                                 tx_section, tx_startprb, tx_numprb, tx_udcomp},
                    {16'hBEEF, 4'h3, frame, 4'h7, 6'd21, sym, 12'hABC, 10'd5, nprb, 8'h91});
                chk("size", tx_size, exp_size);
                chk("seq_id", tx_seq_id, exp_seq);
            end
            if (prev_hold)
                chk("hold_stable", {src_valid, src_sop, src_eop, src_data}, {1'b1, prev_beat});
            dfire = din_valid & din_ready;
            if (dfire) sent++;
            if (stall_left > 0) begin
                if (dfire) stall_acc++;
                if (stall_left == 1) begin
                    chk("stall_din_ready", din_ready, 1'b0);
                    chk("stall_accepts", 32'(stall_acc), 32'd3);
                end
                stall_left--;
            end
            prev_hold = src_valid & ~src_ready;
            prev_beat = {src_sop, src_eop, src_data};
            if (src_valid && src_ready) begin
                exp_data = {base + 32'(4 * beats), base + 32'(4 * beats + 1),
                            base + 32'(4 * beats + 2), base + 32'(4 * beats + 3)};
                chk("beat_data", src_data, exp_data);
                chk("beat_framing", {src_sop, src_eop},
                    {beats == 0, beats == exp_beats - 1});
                chk("seq_hold", tx_seq_id, exp_seq);
                beats++;
                if (beats == exp_beats || (abort > 0 && beats == abort)) begin
                    done = 1'b1;
                    ncyc = cyc + 1;
                    break;
                end
            end
        end
        chk("packet_done", done, 1'b1);
        if (abort == 0 && done) begin
            if (!bp) chk("cycles", 32'(ncyc), 32'(total + 1));
            @(negedge clk);
            din_valid = 1'b0;
            #1 chk("post_eop", {hdr_ready, din_ready, src_valid}, 3'b100);
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 8'd1,   8'h12, 6'd3,  1'b0, 16'h0080, 16'd48,    32'h0000_0001};
        vecs[1] = '{1'b1, 8'd2,   8'h34, 6'd7,  1'b0, 16'h0080, 16'd96,    32'h1000_0000};
        vecs[2] = '{1'b0, 8'd255, 8'h56, 6'd13, 1'b0, 16'h0180, 16'd12240, 32'h2000_0000};
        vecs[3] = '{1'b1, 8'd2,   8'h78, 6'd1,  1'b1, 16'h0080, 16'd96,    32'h3000_0000};
        vecs[4] = '{1'b1, 8'd0,   8'h9A, 6'd2,  1'b0, 16'h0080, 16'd0,     32'h4000_0000};
        vecs[5] = '{1'b0, 8'd1,   8'hBC, 6'd4,  1'b0, 16'h0080, 16'd48,    32'h5000_0000};

        do_reset();
        check_reset_state("reset");

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].rst_before) do_reset();
            if (vecs[i].nprb == 8'd0) begin
                @(negedge clk);
                hdr_valid = 1'b1; hdr_numPrb = 8'd0; hdr_frameId = vecs[i].frame;
                #1 chk("zero_hdr_ready", hdr_ready, 1'b1);
                @(negedge clk);
                hdr_valid = 1'b0;
                for (int c = 0; c < 8; c++) begin
                    #1 chk("zero_idle", {hdr_ready, din_ready, src_valid}, 3'b100);
                    @(negedge clk);
                end
                #1 chk("zero_no_latch", {tx_size, tx_frame, tx_seq_id}, {16'd0, 8'd0, 16'h0080});
            end else begin
                run_packet(vecs[i].nprb, vecs[i].frame, vecs[i].sym, vecs[i].bp,
                           vecs[i].exp_seq, vecs[i].exp_size, vecs[i].base, 0);
            end
        end

        // Sequence counter wrap: packet 257 reuses seq 0
        do_reset();
        for (int p = 0; p < 257; p++) begin
            logic [7:0] p8;
            p8 = p[7:0];
            run_packet(8'd1, 8'h01, 6'd0, 1'b0, {p8, 8'h80}, 16'd48, 32'(p * 16), 0);
        end
        #1 chk("wrap_seq_after_257", tx_seq_id, 16'h0180);

        // Reset in mid-packet after 5 beats of a 4-PRB packet
        do_reset();
        run_packet(8'd4, 8'h22, 6'd9, 1'b0, 16'h0080, 16'd192, 32'hA000_0000, 5);
        @(negedge clk);
        rst = 1'b1; din_valid = 1'b0; src_ready = 1'b1;
        @(negedge clk);
        #1 chk("midrst_valid_drop", src_valid, 1'b0);
        rst = 1'b0;
        check_reset_state("midrst");
        run_packet(8'd1, 8'h33, 6'd5, 1'b0, 16'h0080, 16'd48, 32'hB000_0000, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
